rv_pipe_frontend: RTL and testbench

RV_PIPE_FRONTEND -- requirements
Module: rv_pipe_frontend

---
 rtl/rv_pipe_frontend.sv | 227 ++++++++++++++++++++++
 tb/tb_rv_pipe_frontend.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_frontend.sv
// RV32/64 integer front end: PC/fetch, IF/ID latch, register file with write-through
// bypass, decode and the registered ID/EX stage with load-use stall and branch redirect.
`timescale 1ns/1ps
module rv_pipe_frontend #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              NREGS    = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_pc_pl4,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_illegal,
    output logic            stall_out
);

    localparam int              RIDX_W    = (NREGS == 16) ? 4 : 5;
    localparam logic [6:0]      OP_R      = 7'b0110011;
    localparam logic [6:0]      OP_IMM    = 7'b0010011;
    localparam logic [6:0]      OP_LOAD   = 7'b0000011;
    localparam logic [6:0]      OP_STORE  = 7'b0100011;
    localparam logic [6:0]      OP_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] ZERO_X    = {XLEN{1'b0}};

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] ins);
        return {{(XLEN-12){ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] ins);
        return {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] ins);
        return {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    logic [XLEN-1:0]   pc_r;
    logic              ifid_valid_r;
    logic [31:0]       ifid_instr_r;
    logic [XLEN-1:0]   ifid_pc_r;
    logic [XLEN-1:0]   rf_r [NREGS];

    logic [RIDX_W-1:0] wb_idx_s, rs1_idx_s, rs2_idx_s;
    logic [XLEN-1:0]   rs1_data_s, rs2_data_s, dec_imm_s;
    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [3:0]        dec_alu_op_s;
    logic              dec_alu_src_s, dec_mem_rd_s, dec_mem_wr_s;
    logic              dec_reg_write_s, dec_branch_s, dec_illegal_s;
    logic              uses_rs2_s, stall_s;

    assign imem_addr = pc_r;
    assign stall_out = stall_s;
    assign opcode_s  = ifid_instr_r[6:0];
    assign funct3_s  = ifid_instr_r[14:12];
    assign wb_idx_s  = wb_rd[RIDX_W-1:0];
    assign rs1_idx_s = ifid_instr_r[15 +: RIDX_W];
    assign rs2_idx_s = ifid_instr_r[20 +: RIDX_W];

    // Register read with x0 hardwired to zero and same-cycle write-back bypass.
    always_comb begin
        rs1_data_s = ZERO_X;
        rs2_data_s = ZERO_X;
        if (rs1_idx_s == {RIDX_W{1'b0}}) begin
            rs1_data_s = ZERO_X;
        end else if (wb_en && (wb_idx_s == rs1_idx_s)) begin
            rs1_data_s = wb_data;
        end else begin
            rs1_data_s = rf_r[rs1_idx_s];
        end
        if (rs2_idx_s == {RIDX_W{1'b0}}) begin
            rs2_data_s = ZERO_X;
        end else if (wb_en && (wb_idx_s == rs2_idx_s)) begin
            rs2_data_s = wb_data;
        end else begin
            rs2_data_s = rf_r[rs2_idx_s];
        end
    end

    // Instruction decode of the IF/ID entry.
    always_comb begin
        dec_alu_op_s    = 4'b0000;
        dec_alu_src_s   = 1'b0;
        dec_mem_rd_s    = 1'b0;
        dec_mem_wr_s    = 1'b0;
        dec_reg_write_s = 1'b0;
        dec_branch_s    = 1'b0;
        dec_illegal_s   = 1'b0;
        dec_imm_s       = ZERO_X;
        uses_rs2_s      = 1'b0;
        case (opcode_s)
            OP_R: begin
                dec_alu_op_s    = {ifid_instr_r[30], funct3_s};
                dec_reg_write_s = 1'b1;
                uses_rs2_s      = 1'b1;
            end
            OP_IMM: begin
                dec_alu_op_s    = {(funct3_s == 3'b101) ? ifid_instr_r[30] : 1'b0, funct3_s};
                dec_alu_src_s   = 1'b1;
                dec_reg_write_s = 1'b1;
                dec_imm_s       = imm_i(ifid_instr_r);
            end
            OP_LOAD: begin
                dec_alu_src_s   = 1'b1;
                dec_mem_rd_s    = 1'b1;
                dec_reg_write_s = 1'b1;
                dec_imm_s       = imm_i(ifid_instr_r);
            end
            OP_STORE: begin
                dec_alu_src_s   = 1'b1;
                dec_mem_wr_s    = 1'b1;
                dec_imm_s       = imm_s(ifid_instr_r);
                uses_rs2_s      = 1'b1;
            end
            OP_BRANCH: begin
                dec_alu_op_s    = 4'b1000;
                dec_branch_s    = 1'b1;
                dec_imm_s       = imm_b(ifid_instr_r);
                uses_rs2_s      = 1'b1;
            end
            default: begin
                dec_illegal_s   = 1'b1;
            end
        endcase
    end

    // Load-use hazard: the load in EX feeds a source of the instruction in ID.
    always_comb begin
        stall_s = ex_valid && ex_mem_rd && (ex_rd != 5'd0) && ifid_valid_r &&
                  ((ex_rd == ifid_instr_r[19:15]) ||
                   (uses_rs2_s && (ex_rd == ifid_instr_r[24:20])));
    end

    // Program counter: redirect beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (branch_taken) begin
            pc_r <= branch_target;
        end else if (stall_s) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= pc_r + PC_STEP;
        end
    end

    // IF/ID latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= 32'h0000_0000;
            ifid_pc_r    <= ZERO_X;
        end else if (branch_taken) begin
            ifid_valid_r <= 1'b0;
        end else if (!stall_s) begin
            ifid_valid_r <= 1'b1;
            ifid_instr_r <= imem_rdata;
            ifid_pc_r    <= pc_r;
        end
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= ZERO_X;
            end
        end else if (wb_en && (wb_idx_s != {RIDX_W{1'b0}})) begin
            rf_r[wb_idx_s] <= wb_data;
        end
    end

    // ID/EX register; reset, redirect, stall and empty ID all produce a bubble.
    always_ff @(posedge clk) begin
        if (rst || branch_taken || stall_s || !ifid_valid_r) begin
            ex_valid     <= 1'b0;
            ex_pc        <= ZERO_X;
            ex_pc_pl4    <= ZERO_X;
            ex_rs1_data  <= ZERO_X;
            ex_rs2_data  <= ZERO_X;
            ex_imm       <= ZERO_X;
            ex_rd        <= 5'd0;
            ex_alu_op    <= 4'b0000;
            ex_alu_src   <= 1'b0;
            ex_mem_rd    <= 1'b0;
            ex_mem_wr    <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_pc        <= ifid_pc_r;
            ex_pc_pl4    <= ifid_pc_r + PC_STEP;
            ex_rs1_data  <= rs1_data_s;
            ex_rs2_data  <= rs2_data_s;
            ex_imm       <= dec_imm_s;
            ex_rd        <= ifid_instr_r[11:7];
            ex_alu_op    <= dec_alu_op_s;
            ex_alu_src   <= dec_alu_src_s;
            ex_mem_rd    <= dec_mem_rd_s;
            ex_mem_wr    <= dec_mem_wr_s;
            ex_reg_write <= dec_reg_write_s;
            ex_branch    <= dec_branch_s;
            ex_illegal   <= dec_illegal_s;
        end
    end

endmodule

// File: tb/tb_rv_pipe_frontend.sv
// Directed bench for rv_pipe_frontend: expected ID/EX bundles are queued per program PC
// and compared when the DUT issues them; a 64-bit instance checks wide sign extension.
`timescale 1ns/1ps
module tb_rv_pipe_frontend;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_pl4;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_write;
        logic        branch;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, branch_taken, wb_en;
    logic [31:0] branch_target, wb_data, imem_addr, imem_rdata;
    logic [4:0]  wb_rd;
    logic        ex_valid, ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_write, ex_branch, ex_illegal;
    logic [31:0] ex_pc, ex_pc_pl4, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic        stall_out;

    logic [63:0] imem_addr_64, imem_rdata_64_unused, ex_pc_64, ex_pc_pl4_64;
    logic [63:0] ex_rs1_64, ex_rs2_64, ex_imm_64;
    logic [31:0] imem_rdata_64;
    logic [4:0]  ex_rd_64;
    logic [3:0]  ex_alu_op_64;
    logic        ex_valid_64, ex_alu_src_64, ex_mem_rd_64, ex_mem_wr_64;
    logic        ex_reg_write_64, ex_branch_64, ex_illegal_64, stall_64;

    logic [31:0] imem [0:255];
    exp_t        sb_q [$];
    exp_t        mk_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata    = (imem_addr < 32'd1024) ? imem[imem_addr[9:2]] : 32'h0000_0013;
    assign imem_rdata_64 = (imem_addr_64 < 64'd1024) ? imem[imem_addr_64[9:2]] : 32'h0000_0013;
    assign imem_rdata_64_unused = 64'd0;

    rv_pipe_frontend dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_pl4(ex_pc_pl4),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_write(ex_reg_write),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal), .stall_out(stall_out)
    );

    rv_pipe_frontend #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr_64), .imem_rdata(imem_rdata_64),
        .branch_taken(branch_taken), .branch_target({32'h0, branch_target}),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data({32'h0, wb_data}),
        .ex_valid(ex_valid_64), .ex_pc(ex_pc_64), .ex_pc_pl4(ex_pc_pl4_64),
        .ex_rs1_data(ex_rs1_64), .ex_rs2_data(ex_rs2_64), .ex_imm(ex_imm_64),
        .ex_rd(ex_rd_64), .ex_alu_op(ex_alu_op_64), .ex_alu_src(ex_alu_src_64),
        .ex_mem_rd(ex_mem_rd_64), .ex_mem_wr(ex_mem_wr_64), .ex_reg_write(ex_reg_write_64),
        .ex_branch(ex_branch_64), .ex_illegal(ex_illegal_64), .stall_out(stall_64)
    );

    function automatic exp_t cur_obs();
        return {ex_pc, ex_pc_pl4, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_alu_op,
                ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_write, ex_branch, ex_illegal};
    endfunction

    // Queue one expected issue; unspecified fields can be left out of the compare.
    task automatic push(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd, input logic [3:0] alu_op,
                        input logic [5:0] ctl, input bit chk_rs2, input bit chk_imm,
                        input bit chk_alu);
        exp_t e;
        exp_t m;
        e = {pc, pc + 32'd4, rs1, rs2, imm, rd, alu_op, ctl};
        m = {175{1'b1}};
        if (!chk_rs2) m.rs2 = 32'd0;
        if (!chk_imm) m.imm = 32'd0;
        if (!chk_alu) begin
            m.alu_op  = 4'd0;
            m.alu_src = 1'b0;
        end
        sb_q.push_back(e);
        mk_q.push_back(m);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_bubble(input string tag);
        n_assert++;
        assert ((cur_obs() === 175'd0) && (ex_valid === 1'b0))
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h/%0b expected=0/0", tag, cur_obs(), ex_valid);
        end
    endtask

    // One clock, then compare any issued instruction against the head of the scoreboard.
    task automatic tick();
        exp_t e;
        exp_t m;
        @(posedge clk);
        #1;
        if (ex_valid === 1'b1 && sb_q.size() != 0 && ex_pc === sb_q[0].pc) begin
            e = sb_q.pop_front();
            m = mk_q.pop_front();
            n_assert++;
            assert ((cur_obs() & m) === (e & m))
            else begin
                n_fail++;
                $error("FAIL sb_pc_%0h observed=%0h expected=%0h", e.pc, cur_obs() & m, e & m);
            end
        end
    endtask

    initial begin
        // ctl order: alu_src, mem_rd, mem_wr, reg_write, branch, illegal
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        imem[0]   = 32'h0050_0093;  // addi x1,x0,5
        imem[1]   = 32'h0031_8233;  // add  x4,x3,x3
        imem[2]   = 32'h0000_A103;  // lw   x2,0(x1)
        imem[3]   = 32'h0021_01B3;  // add  x3,x2,x2
        imem[4]   = 32'h0000_2283;  // lw   x5,0(x0)
        imem[5]   = 32'h0012_8313;  // addi x6,x5,1
        imem[64]  = 32'hFE00_0CE3;  // beq  x0,x0,-8 (rd field 25)
        imem[65]  = 32'h0000_037F;  // opcode 0x7F
        imem[66]  = 32'h0000_03B3;  // add  x7,x0,x0
        imem[67]  = 32'h4041_8433;  // sub  x8,x3,x4
        imem[68]  = 32'h4031_D493;  // srai x9,x3,3
        imem[69]  = 32'hFFF0_0513;  // addi x10,x0,-1
        imem[70]  = 32'hFE30_AE23;  // sw   x3,-4(x1)
        imem[128] = 32'h0000_2583;  // lw   x11,0(x0)
        imem[129] = 32'h0005_8633;  // add  x12,x11,x0

        rst = 1'b1; branch_taken = 1'b0; branch_target = 32'd0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        tick();
        tick();
        check_bubble("reset_bundle");
        check("reset_pc", {32'd0, imem_addr}, 64'd0);
        check("reset_stall", {63'd0, stall_out}, 64'd0);

        push(32'h000, 32'h0, 32'h0, 32'h5, 5'd1, 4'b0000, 6'b100100, 1'b0, 1'b1, 1'b1);
        push(32'h004, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 5'd4, 4'b0000, 6'b000100, 1'b1, 1'b0, 1'b1);
        push(32'h008, 32'h0, 32'h0, 32'h0, 5'd2, 4'b0000, 6'b110100, 1'b0, 1'b1, 1'b1);
        push(32'h00C, 32'h0, 32'h0, 32'h0, 5'd3, 4'b0000, 6'b000100, 1'b1, 1'b0, 1'b1);
        push(32'h010, 32'h0, 32'h0, 32'h0, 5'd5, 4'b0000, 6'b110100, 1'b0, 1'b1, 1'b1);
        push(32'h100, 32'h0, 32'h0, 32'hFFFFFFF8, 5'd25, 4'b1000, 6'b000010, 1'b1, 1'b1, 1'b1);
        push(32'h104, 32'h0, 32'h0, 32'h0, 5'd6, 4'b0000, 6'b000001, 1'b1, 1'b0, 1'b0);
        push(32'h108, 32'h0, 32'h0, 32'h0, 5'd7, 4'b0000, 6'b000100, 1'b1, 1'b0, 1'b1);
        push(32'h10C, 32'hDEADBEEF, 32'h0, 32'h0, 5'd8, 4'b1000, 6'b000100, 1'b1, 1'b0, 1'b1);
        push(32'h110, 32'hDEADBEEF, 32'h0, 32'h403, 5'd9, 4'b1101, 6'b100100, 1'b0, 1'b1, 1'b1);
        push(32'h114, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd10, 4'b0000, 6'b100100, 1'b0, 1'b1, 1'b1);
        push(32'h118, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd28, 4'b0000, 6'b101000, 1'b1, 1'b1, 1'b1);

        rst = 1'b0;
        tick();                     // IF/ID <= addi@0
        tick();                     // addi issues
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        tick();                     // add x4,x3,x3 issues with bypassed x3
        wb_en = 1'b0;
        tick();                     // lw x2 in EX, add x3 in ID
        check("lw_use_stall", {63'd0, stall_out}, 64'd1);
        check("lw_use_pc", {32'd0, imem_addr}, 64'h10);
        tick();
        check("stall_bubble", {63'd0, ex_valid}, 64'd0);
        check("stall_once", {63'd0, stall_out}, 64'd0);
        check("stall_pc_hold", {32'd0, imem_addr}, 64'h10);
        tick();                     // add x3 issues
        check("post_stall_pc", {32'd0, imem_addr}, 64'h14);
        tick();                     // lw x5 in EX, addi x6 in ID
        check("stall_before_redirect", {63'd0, stall_out}, 64'd1);
        branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        check("redirect_pc", {32'd0, imem_addr}, 64'h100);
        check("redirect_bubble", {63'd0, ex_valid}, 64'd0);
        check("redirect_no_stall", {63'd0, stall_out}, 64'd0);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
        tick();
        tick();                     // beq issues
        check("beq_imm_64", ex_imm_64, 64'hFFFF_FFFF_FFFF_FFF8);
        check("beq_branch_64", {63'd0, ex_branch_64}, 64'd1);
        tick();                     // illegal issues
        tick();                     // add x7,x0,x0 issues after x0 writes
        wb_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("program_drained", 64'(sb_q.size()), 64'd0);

        // Reset landing on a stalled cycle together with redirect and write-back.
        push(32'h200, 32'h0, 32'h0, 32'h0, 5'd11, 4'b0000, 6'b110100, 1'b0, 1'b1, 1'b1);
        branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 8 && stall_out !== 1'b1; i++) tick();
        check("second_stall_seen", {63'd0, stall_out}, 64'd1);
        rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hCAFEF00D;
        tick();
        rst = 1'b0; branch_taken = 1'b0; wb_en = 1'b0;
        check("rst_over_branch_pc", {32'd0, imem_addr}, 64'd0);
        check_bubble("rst_mid_stall_bundle");
        check("rst_mid_stall_stall", {63'd0, stall_out}, 64'd0);
        push(32'h000, 32'h0, 32'h0, 32'h5, 5'd1, 4'b0000, 6'b100100, 1'b0, 1'b1, 1'b1);
        push(32'h004, 32'h0, 32'h0, 32'h0, 5'd4, 4'b0000, 6'b000100, 1'b1, 1'b0, 1'b1);
        tick();
        check("rst_no_hold_pc", {32'd0, imem_addr}, 64'h4);
        for (int i = 0; i < 6 && sb_q.size() != 0; i++) tick();
        check("final_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
